// File: rtl/lcd_nibble_tx.sv
// lcd_nibble_tx: sends bytes to an HD44780-style LCD over a 4-bit bus as two
// nibbles (high first), each framed by setup / E-high / gap timing, followed
// by a post-byte wait that is longer for the slow clear/home commands.
// Optional macro LCD_NIBBLE_TX_INIT_EN adds a power-up sequence that sends
// nibbles 0x3,0x3,0x3,0x2 (rs=0) before the block first becomes ready.
module lcd_nibble_tx #(
    parameter int unsigned SETUP_CYC     = 2,
    parameter int unsigned E_HIGH_CYC    = 4,
    parameter int unsigned GAP_CYC       = 3,
    parameter int unsigned CMD_WAIT_CYC  = 10,
    parameter int unsigned CLR_WAIT_CYC  = 50,
    parameter int unsigned INIT_WAIT_CYC = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       lcd_rs,
    output logic [3:0] lcd_d,
    output logic       lcd_e,
    output logic       busy
);

    localparam int unsigned MAX_A = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
    localparam int unsigned MAX_B = (GAP_CYC > CMD_WAIT_CYC) ? GAP_CYC : CMD_WAIT_CYC;
    localparam int unsigned MAX_C = (CLR_WAIT_CYC > INIT_WAIT_CYC) ? CLR_WAIT_CYC : INIT_WAIT_CYC;
    localparam int unsigned MAX_AB = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_P  = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int unsigned CNT_W  = $clog2(MAX_P + 1);

    typedef enum logic [2:0] {
`ifdef LCD_NIBBLE_TX_INIT_EN
        S_INIT,
`endif
        S_IDLE,
        S_SETUP,
        S_EHIGH,
        S_GAP,
        S_WAIT
    } state_t;

`ifdef LCD_NIBBLE_TX_INIT_EN
    localparam state_t RESET_STATE = S_INIT;
`else
    localparam state_t RESET_STATE = S_IDLE;
`endif

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               rs_q, rs_n;
    logic [7:0]         data_q, data_n;
    logic [1:0]         nib, nib_n;
    logic               e_n, lrs_n;
    logic [3:0]         d_n;
    logic               slow_cmd;
`ifdef LCD_NIBBLE_TX_INIT_EN
    logic               init_q, init_n;
`endif

    assign in_ready = (state == S_IDLE);
    assign busy     = ~in_ready;
    assign slow_cmd = ~rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

    // State, counter, latched byte and registered LCD pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RESET_STATE;
            cnt    <= '0;
            rs_q   <= 1'b0;
            data_q <= '0;
            nib    <= '0;
            lcd_e  <= 1'b0;
            lcd_rs <= 1'b0;
            lcd_d  <= '0;
`ifdef LCD_NIBBLE_TX_INIT_EN
            init_q <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            rs_q   <= rs_n;
            data_q <= data_n;
            nib    <= nib_n;
            lcd_e  <= e_n;
            lcd_rs <= lrs_n;
            lcd_d  <= d_n;
`ifdef LCD_NIBBLE_TX_INIT_EN
            init_q <= init_n;
`endif
        end
    end

    // Next state, counter reload and next pin values; pins are computed from
    // the next state so that they change exactly on state boundaries.
    always_comb begin
        state_n = state;
        cnt_n   = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        rs_n    = rs_q;
        data_n  = data_q;
        nib_n   = nib;
        lrs_n   = lcd_rs;
        d_n     = lcd_d;
`ifdef LCD_NIBBLE_TX_INIT_EN
        init_n  = init_q;
`endif
        case (state)
`ifdef LCD_NIBBLE_TX_INIT_EN
            S_INIT: begin
                state_n = S_SETUP;
                init_n  = 1'b1;
                nib_n   = 2'd0;
                lrs_n   = 1'b0;
                d_n     = 4'h3;
                cnt_n   = CNT_W'(SETUP_CYC - 1);
            end
`endif
            S_IDLE: begin
                if (in_valid) begin
                    state_n = S_SETUP;
                    rs_n    = in_rs;
                    data_n  = in_data;
                    nib_n   = 2'd0;
                    lrs_n   = in_rs;
                    d_n     = in_data[7:4];
                    cnt_n   = CNT_W'(SETUP_CYC - 1);
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    state_n = S_EHIGH;
                    cnt_n   = CNT_W'(E_HIGH_CYC - 1);
                end
            end
            S_EHIGH: begin
                if (cnt == '0) begin
`ifdef LCD_NIBBLE_TX_INIT_EN
                    if (init_q) begin
                        state_n = S_WAIT;
                        cnt_n   = CNT_W'(INIT_WAIT_CYC - 1);
                    end else
`endif
                    if (nib == 2'd0) begin
                        state_n = S_GAP;
                        cnt_n   = CNT_W'(GAP_CYC - 1);
                    end else begin
                        state_n = S_WAIT;
                        cnt_n   = slow_cmd ? CNT_W'(CLR_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);
                    end
                end
            end
            S_GAP: begin
                if (cnt == '0) begin
                    state_n = S_SETUP;
                    nib_n   = 2'd1;
                    d_n     = data_q[3:0];
                    cnt_n   = CNT_W'(SETUP_CYC - 1);
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_n = S_IDLE;
`ifdef LCD_NIBBLE_TX_INIT_EN
                    // init nibbles reuse SETUP/EHIGH/WAIT, looping until the 4th
                    if (init_q) begin
                        if (nib != 2'd3) begin
                            state_n = S_SETUP;
                            nib_n   = nib + 2'd1;
                            d_n     = (nib == 2'd2) ? 4'h2 : 4'h3;
                            cnt_n   = CNT_W'(SETUP_CYC - 1);
                        end else begin
                            init_n  = 1'b0;
                        end
                    end
`endif
                end
            end
            default: state_n = RESET_STATE;
        endcase
        e_n = (state_n == S_EHIGH);
    end

endmodule

// File: tb/tb_lcd_nibble_tx.sv
// tb_lcd_nibble_tx: directed and random byte traffic checked every cycle
// against a timing model computed from offsets since each accepted byte.
module tb_lcd_nibble_tx;

    localparam int SET = 2, EH = 4, GP = 3, CW = 10, CL = 50, IW = 20;
    localparam int INIT_LEN = 4 * (SET + EH + IW) + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_rs = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, lcd_rs, lcd_e, busy;
    logic [3:0] lcd_d;

    int checks = 0;
    int errors = 0;

    lcd_nibble_tx #(
        .SETUP_CYC(SET), .E_HIGH_CYC(EH), .GAP_CYC(GP),
        .CMD_WAIT_CYC(CW), .CLR_WAIT_CYC(CL), .INIT_WAIT_CYC(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_rs(in_rs),
        .in_data(in_data), .in_ready(in_ready), .lcd_rs(lcd_rs),
        .lcd_d(lcd_d), .lcd_e(lcd_e), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int         cyc = 0;     // rising edges since reset release
    bit         have = 1'b0; // a byte has been accepted since reset
    int         acc = 0;     // cyc value during the accepting cycle
    logic [7:0] mb = 8'h00;
    logic       mrs = 1'b0;

    function automatic int byte_len(input logic rs, input logic [7:0] b);
        int w;
        w = (!rs && b >= 8'h01 && b <= 8'h03) ? CL : CW;
        return 2 * SET + 2 * EH + GP + w + 1;
    endfunction

    function automatic bit init_busy();
`ifdef LCD_NIBBLE_TX_INIT_EN
        return cyc < INIT_LEN;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_ready();
        if (init_busy()) return 1'b0;
        if (!have) return 1'b1;
        return (cyc - acc) >= byte_len(mrs, mb);
    endfunction

    function automatic void m_out(output logic e, output logic rs, output logic [3:0] d);
        int k;
        int c;
        int n;
        e = 1'b0; rs = 1'b0; d = 4'h0;
`ifdef LCD_NIBBLE_TX_INIT_EN
        if (cyc >= 1) begin
            c = cyc - 1;
            n = c / (SET + EH + IW);
            k = c % (SET + EH + IW);
            if (n < 4) begin
                d = (n == 3) ? 4'h2 : 4'h3;
                e = (k >= SET) && (k < SET + EH);
                return;
            end
            d = 4'h2;
        end
`endif
        if (!have) return;
        k  = cyc - acc;
        rs = mrs;
        if (k <= SET + EH + GP) begin
            d = mb[7:4];
            e = (k > SET) && (k <= SET + EH);
        end else begin
            d = mb[3:0];
            e = (k > 2 * SET + EH + GP) && (k <= 2 * SET + 2 * EH + GP);
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc  <= 0;
            have <= 1'b0;
        end else begin
            if (in_valid && m_ready()) begin
                have <= 1'b1;
                acc  <= cyc;
                mb   <= in_data;
                mrs  <= in_rs;
            end
            cyc <= cyc + 1;
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic       ee, er;
        logic [3:0] ed;
        if (rst_n) begin
            m_out(ee, er, ed);
            chk("lcd_e", {7'b0, lcd_e}, {7'b0, ee});
            chk("lcd_rs", {7'b0, lcd_rs}, {7'b0, er});
            chk("lcd_d", {4'b0, lcd_d}, {4'b0, ed});
            chk("in_ready", {7'b0, in_ready}, {7'b0, m_ready()});
            chk("busy", {7'b0, busy}, {7'b0, ~m_ready()});
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL ready_timeout t=%0t actual=0 expected=1", $time);
        end
    endtask

    // Drive one byte at a negedge while ready; it is accepted on the next edge.
    task automatic start_byte(input logic rs, input logic [7:0] b);
        wait_ready();
        in_valid = 1'b1;
        in_rs    = rs;
        in_data  = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_e", {7'b0, lcd_e}, 8'h00);
        chk("rst_d", {4'b0, lcd_d}, 8'h00);
        chk("rst_rs", {7'b0, lcd_rs}, 8'h00);
`ifdef LCD_NIBBLE_TX_INIT_EN
        chk("rst_ready", {7'b0, in_ready}, 8'h00);
`else
        chk("rst_ready", {7'b0, in_ready}, 8'h01);
`endif
        @(negedge clk);
        rst_n = 1'b1;

`ifdef LCD_NIBBLE_TX_INIT_EN
        for (int n = 1; n <= INIT_LEN; n++) begin
            @(negedge clk);
            if (n == 3) chk("init_e1", {7'b0, lcd_e}, 8'h01);
            if (n == 82) chk("init_d4", {4'b0, lcd_d}, 8'h02);
            if (n == INIT_LEN - 1) chk("init_ready104", {7'b0, in_ready}, 8'h00);
            if (n == INIT_LEN) chk("init_ready105", {7'b0, in_ready}, 8'h01);
        end
`endif

        // rs=1 0x48 with literal timing pins
        start_byte(1'b1, 8'h48);
        for (int n = 1; n <= 26; n++) begin
            @(negedge clk);
            case (n)
                1:  chk("b48_d1", {4'b0, lcd_d}, 8'h04);
                2:  chk("b48_e2", {7'b0, lcd_e}, 8'h00);
                3:  chk("b48_e3", {7'b0, lcd_e}, 8'h01);
                6:  chk("b48_e6", {7'b0, lcd_e}, 8'h01);
                7:  chk("b48_e7", {7'b0, lcd_e}, 8'h00);
                9:  chk("b48_d9", {4'b0, lcd_d}, 8'h04);
                10: chk("b48_d10", {4'b0, lcd_d}, 8'h08);
                12: chk("b48_e12", {7'b0, lcd_e}, 8'h01);
                16: chk("b48_e16", {7'b0, lcd_e}, 8'h00);
                25: chk("b48_ready25", {7'b0, in_ready}, 8'h00);
                26: chk("b48_ready26", {7'b0, in_ready}, 8'h01);
                default: ;
            endcase
        end

        // rs=0 0x01: slow wait
        start_byte(1'b0, 8'h01);
        for (int n = 1; n <= 66; n++) begin
            @(negedge clk);
            case (n)
                15: chk("clr_e15", {7'b0, lcd_e}, 8'h01);
                16: chk("clr_e16", {7'b0, lcd_e}, 8'h00);
                30: chk("clr_rs", {7'b0, lcd_rs}, 8'h00);
                65: chk("clr_ready65", {7'b0, in_ready}, 8'h00);
                66: chk("clr_ready66", {7'b0, in_ready}, 8'h01);
                default: ;
            endcase
        end

        // back-to-back 0x41, 0x42 with in_valid held
        wait_ready();
        in_valid = 1'b1;
        in_rs    = 1'b1;
        in_data  = 8'h41;
        @(posedge clk);
        #1 in_data = 8'h42;
        for (int n = 1; n <= 26; n++) begin
            @(negedge clk);
            if (n == 25) chk("b2b_ready25", {7'b0, in_ready}, 8'h00);
            if (n == 26) chk("b2b_ready26", {7'b0, in_ready}, 8'h01);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) chk("b2b_busy", {7'b0, busy}, 8'h01);
            if (n == 10) chk("b2b_lo", {4'b0, lcd_d}, 8'h02);
        end

        // async reset during the first E-high phase
        start_byte(1'b1, 8'hA5);
        for (int n = 1; n <= 4; n++) @(negedge clk);
        chk("rstmid_e_before", {7'b0, lcd_e}, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_e", {7'b0, lcd_e}, 8'h00);
        chk("rstmid_d", {4'b0, lcd_d}, 8'h00);
`ifdef LCD_NIBBLE_TX_INIT_EN
        chk("rstmid_ready", {7'b0, in_ready}, 8'h00);
`else
        chk("rstmid_ready", {7'b0, in_ready}, 8'h01);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready();
        for (int n = 1; n <= 8; n++) @(negedge clk);
        chk("rstmid_no_resume", {7'b0, lcd_e}, 8'h00);

        // random traffic, including requests while busy
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) == 0);
            in_rs    = $urandom_range(0, 1);
            in_data  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_ready();
        for (int n = 1; n <= 4; n++) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_nibble_tx.md
LCD_NIBBLE_TX -- requirements
Module: lcd_nibble_tx

Interface
REQ-001 Parameter SETUP_CYC, default 2: cycles RS/D are stable before E rises (>=1).
REQ-002 Parameter E_HIGH_CYC, default 4: cycles E is high per nibble (>=1).
REQ-003 Parameter GAP_CYC, default 3: cycles between E fall and the next nibble's data change (>=1).
REQ-004 Parameter CMD_WAIT_CYC, default 10: post-byte wait for ordinary bytes (>=1).
REQ-005 Parameter CLR_WAIT_CYC, default 50: post-byte wait for slow commands (>=1).
REQ-006 Parameter INIT_WAIT_CYC, default 20: wait after each init nibble (>=1).
REQ-007 clk  in  1  single clock, all state on rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 in_valid  in  1  byte request.
REQ-010 in_rs  in  1  register select (0 command, 1 data).
REQ-011 in_data  in  8  byte to send.
REQ-012 in_ready  out  1  high only in IDLE; transfer on in_valid&&in_ready.
REQ-013 lcd_rs  out  1  LCD RS pin.
REQ-014 lcd_d  out  4  LCD D7..D4.
REQ-015 lcd_e  out  1  LCD enable strobe.
REQ-016 busy  out  1  inverse of in_ready.

Function
REQ-017 FSM states: INIT (macro only), IDLE, SETUP, EHIGH, GAP, WAIT; single down-counter sized to the largest parameter.
REQ-018 On accept (cycle 0): latch in_rs/in_data; next state SETUP for nibble hi; in_data/in_rs ignored until IDLE.
REQ-019 SETUP: lcd_rs=latched rs, lcd_d=current nibble, lcd_e=0, SETUP_CYC cycles; then EHIGH.
REQ-020 EHIGH: lcd_e=1, RS/D unchanged, E_HIGH_CYC cycles; then GAP after nibble hi, WAIT after nibble lo.
REQ-021 GAP: lcd_e=0, RS/D held, GAP_CYC cycles; then SETUP for nibble lo (in_data[3:0]).
REQ-022 WAIT: lcd_e=0, RS/D held; length CLR_WAIT_CYC if rs=0 and byte in {0x01,0x02,0x03}, else CMD_WAIT_CYC; then IDLE.
REQ-023 Byte latency accept->in_ready: 2*SETUP_CYC+2*E_HIGH_CYC+GAP_CYC+wait+1 cycles.
REQ-024 lcd_e, lcd_rs, lcd_d are registered outputs; lcd_e never glitches and is high only in EHIGH.
REQ-025 in_valid asserted back-to-back: next byte accepted on the first IDLE cycle, no extra bubble.
REQ-026 in_valid while busy: no effect, no queueing.

Reset
REQ-027 rst_n low asynchronously forces lcd_e=0, lcd_rs=0, lcd_d=0, counter=0, mid-byte transfer discarded.
REQ-028 Reset state IDLE (in_ready=1) without macro; INIT (in_ready=0) with macro.
REQ-029 After rst_n deasserts, first state change occurs on the first rising clk edge.

Configuration
REQ-030 Macro LCD_NIBBLE_TX_INIT_EN defined: after reset, send nibbles 0x3,0x3,0x3,0x2 with rs=0, each as SETUP/EHIGH then INIT_WAIT_CYC wait, then IDLE.
REQ-031 Macro undefined: no INIT state or logic; block starts in IDLE.

Verification
REQ-032 Defaults, no macro, send rs=1 0x48 at cycle 0 -> D=0x4 cycles 1-9 with E high cycles 3-6; D=0x8 cycles 10-25 with E high 12-15; in_ready high at cycle 26.
REQ-033 Send rs=0 0x01 -> second E falls at cycle 15, WAIT 50 cycles, in_ready high at cycle 66; lcd_rs=0 throughout.
REQ-034 in_valid held high with bytes 0x41,0x42 -> second accept exactly at cycle 26, no byte dropped or duplicated.
REQ-035 rst_n low at cycle 4 (during EHIGH) -> lcd_e=0 immediately without a clock edge; after release, in_ready=1 and the old byte is not resumed.
REQ-036 Macro defined -> four E pulses with D=3,3,3,2, rs=0, each followed by 20 idle cycles; in_ready first high at cycle 4*(2+4+20)+1=105 after reset release.
